proc_mc_ctrl: RTL and testbench



---
 rtl/proc_mc_ctrl_if.sv | 37 +++
 rtl/proc_mc_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_proc_mc_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_mc_ctrl_if.sv
// Control/memory-handshake bundle between the multicycle controller and the
// datapath plus instruction/data memories.
interface proc_mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instr;
    logic             iReady;
    logic             dReady;
    logic             Zero;
    logic             iReq;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             ALUSrc;
    logic [3:0]       ALUCtrl;
    logic             RegWrite;
    logic             MemToReg;
    logic             loadPC;
    logic             PCSrc;
    logic             halt;
    logic [1:0]       halt_cause;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;

    // The controller drives the strobes; memories and datapath drive the rest.
    modport master (
        input  instr, iReady, dReady, Zero,
        output iReq, MemRead, MemWrite, IRWrite, ALUSrc, ALUCtrl, RegWrite,
               MemToReg, loadPC, PCSrc, halt, halt_cause, cycle_cnt, instret_cnt
    );

    modport slave (
        output instr, iReady, dReady, Zero,
        input  iReq, MemRead, MemWrite, IRWrite, ALUSrc, ALUCtrl, RegWrite,
               MemToReg, loadPC, PCSrc, halt, halt_cause, cycle_cnt, instret_cnt
    );
endinterface

// File: rtl/proc_mc_ctrl.sv
// Multicycle RV32I control unit: sequences IF/ID/EX/MEM/WB, stalls on memory
// handshakes with an optional timeout, and keeps cycle/retire counters.
module proc_mc_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 0
) (
    input  logic           clk,
    input  logic           rst,
    proc_mc_ctrl_if.master bus
);
    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    typedef enum logic [2:0] {IF, ID, EX, MEM, WB, HALT} StateT;

    StateT             state;
    logic [31:0]       ir;
    logic [WAIT_W-1:0] waitCnt;
    logic [CNT_W-1:0]  cycleCnt;
    logic [CNT_W-1:0]  instretCnt;
    logic [1:0]        haltCause;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       isR, isI, isLw, isSw, isBeq, isLegal;
    logic       timedOut;
    logic [3:0] aluOp;
    logic       unusedIrBits;

    assign opcode   = ir[6:0];
    assign funct3   = ir[14:12];
    assign funct7b5 = ir[30];
    assign isR      = (opcode == OP_R);
    assign isI      = (opcode == OP_I);
    assign isLw     = (opcode == OP_LW);
    assign isSw     = (opcode == OP_SW);
    assign isBeq    = (opcode == OP_BEQ);
    assign isLegal  = isR | isI | isLw | isSw | isBeq;
    assign timedOut = (TIMEOUT > 0) && (waitCnt == WAIT_W'(TIMEOUT));

    // Register numbers and immediates belong to the datapath, not to control.
    assign unusedIrBits = ^{ir[31], ir[29:15], ir[11:7]};

    // funct7[5] means SUB only for register ops; on immediates it is imm data.
    always_comb begin
        aluOp = ALU_ADD;
        case (funct3)
            3'b000:  aluOp = (isR && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b111:  aluOp = ALU_AND;
            3'b110:  aluOp = ALU_OR;
            3'b100:  aluOp = ALU_XOR;
            3'b010:  aluOp = ALU_SLT;
            3'b001:  aluOp = ALU_SLL;
            3'b101:  aluOp = funct7b5 ? ALU_SRA : ALU_SRL;
            default: aluOp = ALU_ADD;
        endcase
    end

    always_comb begin
        bus.iReq     = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.ALUSrc   = 1'b0;
        bus.ALUCtrl  = 4'b0000;
        bus.RegWrite = 1'b0;
        bus.MemToReg = 1'b0;
        bus.loadPC   = 1'b0;
        bus.PCSrc    = 1'b0;
        bus.halt     = 1'b0;
        case (state)
            IF: begin
                bus.iReq    = 1'b1;
                bus.IRWrite = bus.iReady;
            end
            EX: begin
                if (isBeq) begin
                    bus.ALUCtrl = ALU_SUB;
                    bus.loadPC  = 1'b1;
                    bus.PCSrc   = bus.Zero;
                end else if (isLw || isSw) begin
                    bus.ALUSrc  = 1'b1;
                    bus.ALUCtrl = ALU_ADD;
                end else begin
                    bus.ALUSrc  = isI;
                    bus.ALUCtrl = aluOp;
                end
            end
            MEM: begin
                bus.MemRead  = isLw;
                bus.MemWrite = isSw;
                bus.loadPC   = isSw && bus.dReady;
            end
            WB: begin
                bus.RegWrite = 1'b1;
                bus.MemToReg = isLw;
                bus.loadPC   = 1'b1;
            end
            HALT: bus.halt = 1'b1;
            default: ;
        endcase
    end

    assign bus.halt_cause  = haltCause;
    assign bus.cycle_cnt   = cycleCnt;
    assign bus.instret_cnt = instretCnt;

    // The wait counter defaults to zero so it clears on every state change;
    // only a stalled IF/MEM cycle keeps it counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IF;
            ir         <= '0;
            waitCnt    <= '0;
            cycleCnt   <= '0;
            instretCnt <= '0;
            haltCause  <= 2'b00;
        end else if (state != HALT) begin
            cycleCnt <= cycleCnt + 1'b1;
            waitCnt  <= '0;
            if (bus.loadPC) begin
                instretCnt <= instretCnt + 1'b1;
            end
            case (state)
                IF: begin
                    if (bus.iReady) begin
                        ir    <= bus.instr;
                        state <= ID;
                    end else if (timedOut) begin
                        state     <= HALT;
                        haltCause <= 2'b10;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                ID: begin
                    if (isLegal) begin
                        state <= EX;
                    end else begin
                        state     <= HALT;
                        haltCause <= 2'b01;
                    end
                end
                EX: begin
                    if (isBeq) begin
                        state <= IF;
                    end else if (isLw || isSw) begin
                        state <= MEM;
                    end else begin
                        state <= WB;
                    end
                end
                MEM: begin
                    if (bus.dReady) begin
                        state <= isLw ? WB : IF;
                    end else if (timedOut) begin
                        state     <= HALT;
                        haltCause <= 2'b10;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                WB: state <= IF;
                default: state <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_proc_mc_ctrl.sv
// Directed bench for proc_mc_ctrl: a per-cycle strobe table over a mixed
// instruction stream plus hand sequences for halt, reset, timeout and wrap.
module tb_proc_mc_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        iReady;
    logic        dReady;
    logic        zero;

    int checks = 0;
    int passes = 0;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_SW   = 32'h0030A223;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_SRAI = 32'h4020D193;
    localparam logic [31:0] I_ADDI = 32'hC0008193;
    localparam logic [31:0] I_ILL  = 32'h0000007F;
    localparam logic [31:0] I_JUNK = 32'hFFFFFFFF;

    // Strobe word: iReq IRWrite MemRead MemWrite ALUSrc ALUCtrl[3:0] RegWrite MemToReg loadPC PCSrc halt
    localparam logic [13:0] C_IFWAIT = 14'b1_0_0_0_0_0000_0_0_0_0_0;
    localparam logic [13:0] C_IFGO   = 14'b1_1_0_0_0_0000_0_0_0_0_0;
    localparam logic [13:0] C_ID     = 14'b0_0_0_0_0_0000_0_0_0_0_0;
    localparam logic [13:0] C_EXADD  = 14'b0_0_0_0_0_0010_0_0_0_0_0;
    localparam logic [13:0] C_EXSUB  = 14'b0_0_0_0_0_0110_0_0_0_0_0;
    localparam logic [13:0] C_EXIMM  = 14'b0_0_0_0_1_0010_0_0_0_0_0;
    localparam logic [13:0] C_EXSRAI = 14'b0_0_0_0_1_1010_0_0_0_0_0;
    localparam logic [13:0] C_BEQT   = 14'b0_0_0_0_0_0110_0_0_1_1_0;
    localparam logic [13:0] C_BEQN   = 14'b0_0_0_0_0_0110_0_0_1_0_0;
    localparam logic [13:0] C_MEMRD  = 14'b0_0_1_0_0_0000_0_0_0_0_0;
    localparam logic [13:0] C_MEMWR  = 14'b0_0_0_1_0_0000_0_0_0_0_0;
    localparam logic [13:0] C_MEMWRD = 14'b0_0_0_1_0_0000_0_0_1_0_0;
    localparam logic [13:0] C_WBALU  = 14'b0_0_0_0_0_0000_1_0_1_0_0;
    localparam logic [13:0] C_WBLW   = 14'b0_0_0_0_0_0000_1_1_1_0_0;
    localparam logic [13:0] C_HALT   = 14'b0_0_0_0_0_0000_0_0_0_0_1;

    typedef struct {
        logic [31:0] instr;
        logic        iReady;
        logic        dReady;
        logic        zero;
        logic [13:0] expCtl;
    } VecT;

    VecT vecs[$];

    proc_mc_ctrl_if #(.CNT_W(32)) busA ();
    proc_mc_ctrl_if #(.CNT_W(4))  busB ();

    assign busA.instr  = instr;
    assign busA.iReady = iReady;
    assign busA.dReady = dReady;
    assign busA.Zero   = zero;
    assign busB.instr  = instr;
    assign busB.iReady = iReady;
    assign busB.dReady = dReady;
    assign busB.Zero   = zero;

    proc_mc_ctrl #(.CNT_W(32), .TIMEOUT(0)) dutA (.clk(clk), .rst(rst), .bus(busA.master));
    proc_mc_ctrl #(.CNT_W(4),  .TIMEOUT(4)) dutB (.clk(clk), .rst(rst), .bus(busB.master));

    always #5 clk = ~clk;

    function automatic logic [13:0] ctlA();
        return {busA.iReq, busA.IRWrite, busA.MemRead, busA.MemWrite, busA.ALUSrc,
                busA.ALUCtrl, busA.RegWrite, busA.MemToReg, busA.loadPC, busA.PCSrc, busA.halt};
    endfunction

    function automatic logic [13:0] ctlB();
        return {busB.iReq, busB.IRWrite, busB.MemRead, busB.MemWrite, busB.ALUSrc,
                busB.ALUCtrl, busB.RegWrite, busB.MemToReg, busB.loadPC, busB.PCSrc, busB.halt};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end else begin
            passes++;
        end
    endtask

    task automatic addVec(input logic [31:0] in, input logic ir, input logic dr, input logic z,
                          input logic [13:0] exp);
        vecs.push_back('{in, ir, dr, z, exp});
    endtask

    // Drive one cycle's inputs just after a falling edge, check, then move to the next falling edge.
    task automatic applyStimulus(input VecT v, input int idx);
        instr  = v.instr;
        iReady = v.iReady;
        dReady = v.dReady;
        zero   = v.zero;
        #1;
        checkOutput($sformatf("vec%0d ctl", idx), {18'b0, ctlA()}, {18'b0, v.expCtl});
        @(negedge clk);
    endtask

    task automatic applyReset();
        rst    = 1'b1;
        instr  = 32'h0;
        iReady = 1'b0;
        dReady = 1'b0;
        zero   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // add: IF ID EX WB
        addVec(I_ADD,  1, 0, 0, C_IFGO);
        addVec(I_JUNK, 1, 0, 0, C_ID);
        addVec(I_JUNK, 0, 0, 0, C_EXADD);
        addVec(I_JUNK, 0, 0, 0, C_WBALU);
        // lw with three data-memory stall cycles
        addVec(I_LW,   1, 0, 0, C_IFGO);
        addVec(I_JUNK, 0, 0, 0, C_ID);
        addVec(I_JUNK, 0, 0, 0, C_EXIMM);
        addVec(I_JUNK, 0, 0, 0, C_MEMRD);
        addVec(I_JUNK, 0, 0, 0, C_MEMRD);
        addVec(I_JUNK, 0, 0, 0, C_MEMRD);
        addVec(I_JUNK, 0, 1, 0, C_MEMRD);
        addVec(I_JUNK, 0, 0, 0, C_WBLW);
        // beq taken, then not taken after one fetch stall
        addVec(I_BEQ,  1, 0, 0, C_IFGO);
        addVec(I_JUNK, 0, 0, 0, C_ID);
        addVec(I_JUNK, 0, 0, 1, C_BEQT);
        addVec(I_JUNK, 0, 0, 1, C_IFWAIT);
        addVec(I_BEQ,  1, 0, 1, C_IFGO);
        addVec(I_JUNK, 0, 0, 1, C_ID);
        addVec(I_JUNK, 0, 0, 0, C_BEQN);
        // srai
        addVec(I_SRAI, 1, 0, 0, C_IFGO);
        addVec(I_JUNK, 0, 0, 0, C_ID);
        addVec(I_JUNK, 0, 0, 0, C_EXSRAI);
        addVec(I_JUNK, 0, 0, 0, C_WBALU);
        // sw with one stall cycle
        addVec(I_SW,   1, 0, 0, C_IFGO);
        addVec(I_JUNK, 0, 0, 0, C_ID);
        addVec(I_JUNK, 0, 0, 0, C_EXIMM);
        addVec(I_JUNK, 0, 0, 0, C_MEMWR);
        addVec(I_JUNK, 0, 1, 0, C_MEMWRD);
        // addi with imm bit 30 set must still be ADD
        addVec(I_ADDI, 1, 0, 0, C_IFGO);
        addVec(I_JUNK, 0, 0, 0, C_ID);
        addVec(I_JUNK, 0, 0, 0, C_EXIMM);
        addVec(I_JUNK, 0, 0, 0, C_WBALU);
        // sub
        addVec(I_SUB,  1, 0, 0, C_IFGO);
        addVec(I_JUNK, 0, 0, 0, C_ID);
        addVec(I_JUNK, 0, 0, 0, C_EXSUB);
        addVec(I_JUNK, 0, 0, 0, C_WBALU);

        // Reset state, observed while rst is still high
        rst    = 1'b1;
        instr  = 32'h0;
        iReady = 1'b0;
        dReady = 1'b0;
        zero   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset ctl", {18'b0, ctlA()}, {18'b0, C_IFWAIT});
        checkOutput("reset cause", {30'b0, busA.halt_cause}, 32'h0);
        checkOutput("reset cycle", busA.cycle_cnt, 32'd0);
        checkOutput("reset instret", busA.instret_cnt, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) applyStimulus(vecs[i], i);
        checkOutput("table cycle_cnt", busA.cycle_cnt, 32'd36);
        checkOutput("table instret_cnt", busA.instret_cnt, 32'd8);

        // Illegal opcode halts after ID and freezes the counters
        applyReset();
        instr  = I_ILL;
        iReady = 1'b1;
        @(negedge clk);
        instr = I_ADD;
        @(negedge clk);
        #1;
        checkOutput("illegal ctl", {18'b0, ctlA()}, {18'b0, C_HALT});
        checkOutput("illegal cause", {30'b0, busA.halt_cause}, 32'd1);
        checkOutput("illegal cycle", busA.cycle_cnt, 32'd2);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("halted cycle frozen", busA.cycle_cnt, 32'd2);
        checkOutput("halted ctl sticky", {18'b0, ctlA()}, {18'b0, C_HALT});
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        iReady = 1'b0;
        #1;
        checkOutput("halt exit ctl", {18'b0, ctlA()}, {18'b0, C_IFWAIT});
        checkOutput("halt exit cause", {30'b0, busA.halt_cause}, 32'd0);

        // Reset in the middle of a load abandons it without retiring
        applyReset();
        instr  = I_LW;
        iReady = 1'b1;
        @(negedge clk);
        iReady = 1'b0;
        instr  = I_JUNK;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("midmem ctl", {18'b0, ctlA()}, {18'b0, C_MEMRD});
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        dReady = 1'b1;
        #1;
        checkOutput("midmem reset ctl", {18'b0, ctlA()}, {18'b0, C_IFWAIT});
        checkOutput("midmem instret", busA.instret_cnt, 32'd0);
        dReady = 1'b0;

        // Fetch timeout (TIMEOUT=4): halt on the fifth stalled edge
        applyReset();
        repeat (4) @(negedge clk);
        #1;
        checkOutput("if timeout pre", {18'b0, ctlB()}, {18'b0, C_IFWAIT});
        @(negedge clk);
        #1;
        checkOutput("if timeout ctl", {18'b0, ctlB()}, {18'b0, C_HALT});
        checkOutput("if timeout cause", {30'b0, busB.halt_cause}, 32'd2);
        checkOutput("if timeout cycle", {28'b0, busB.cycle_cnt}, 32'd5);

        // Ready arriving together with the timeout count wins
        applyReset();
        repeat (4) @(negedge clk);
        instr  = I_ADD;
        iReady = 1'b1;
        #1;
        checkOutput("late ready IRWrite", {18'b0, ctlB()}, {18'b0, C_IFGO});
        @(negedge clk);
        iReady = 1'b0;
        #1;
        checkOutput("late ready ID", {18'b0, ctlB()}, {18'b0, C_ID});
        checkOutput("late ready cause", {30'b0, busB.halt_cause}, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("late ready EX", {18'b0, ctlB()}, {18'b0, C_EXADD});

        // Data-memory timeout on a load
        applyReset();
        instr  = I_LW;
        iReady = 1'b1;
        @(negedge clk);
        iReady = 1'b0;
        instr  = I_JUNK;
        repeat (6) @(negedge clk);
        #1;
        checkOutput("mem timeout pre", {18'b0, ctlB()}, {18'b0, C_MEMRD});
        @(negedge clk);
        #1;
        checkOutput("mem timeout ctl", {18'b0, ctlB()}, {18'b0, C_HALT});
        checkOutput("mem timeout cause", {30'b0, busB.halt_cause}, 32'd2);

        // 4-bit counters wrap after 16 cycles of back-to-back adds
        applyReset();
        instr  = I_ADD;
        iReady = 1'b1;
        repeat (15) @(negedge clk);
        checkOutput("wrap cycle 15", {28'b0, busB.cycle_cnt}, 32'd15);
        @(negedge clk);
        checkOutput("wrap cycle 0", {28'b0, busB.cycle_cnt}, 32'd0);
        checkOutput("wrap instret", {28'b0, busB.instret_cnt}, 32'd4);
        checkOutput("wide cycle 16", busA.cycle_cnt, 32'd16);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
